// File: rtl/sync_down_counter_with_load.sv
`default_nettype none
// ============================================================================
// Module   : sync_down_counter_with_load
// Purpose  : Loadable down-counter / timer. Counts from a loaded value to
//            zero, raises a one-cycle borrow pulse on terminal count, then
//            either reloads from the last loaded value or parks in EXPIRED.
//            Fully synchronous, single clock domain.
// Ports    : clock       - system clock, rising-edge active
//            reset       - synchronous active-low reset
//            enable      - count enable (ignored in IDLE / EXPIRED)
//            load        - parallel-load strobe, priority over enable
//            load_value  - value captured into count and reload register
//            auto_reload - 1: reload on terminal count, 0: stop at zero
//            count       - current count (registered)
//            borrow      - one-cycle pulse on terminal count (registered)
//            running     - high while counting
//            expired     - high after a non-reloading terminal count
// Revision : 1.0 - initial release
// ============================================================================
module sync_down_counter_with_load #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             running,
    output logic             expired
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_counting = 2'd1;
    localparam logic [1:0] c_expired  = 2'd2;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_borrow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_count  <= c_zero;
            r_reload <= c_zero;
            r_borrow <= 1'b0;
        end else if (load) begin
            // A load on the terminal-count edge wins, so no borrow is issued.
            r_state  <= c_counting;
            r_count  <= load_value;
            r_reload <= load_value;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_counting: begin
                    if (enable) begin
                        if (r_count != c_zero) begin
                            r_count  <= r_count - c_one;
                            r_borrow <= 1'b0;
                        end else begin
                            // Terminal count replaces the decrement: no wrap.
                            r_borrow <= 1'b1;
                            if (auto_reload) begin
                                r_count <= r_reload;
                            end else begin
                                r_state <= c_expired;
                            end
                        end
                    end else begin
                        // A pause never produces or stretches a borrow.
                        r_borrow <= 1'b0;
                    end
                end
                c_idle: begin
                    r_borrow <= 1'b0;
                end
                c_expired: begin
                    r_borrow <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover to a safe idle state.
                    r_state  <= c_idle;
                    r_count  <= c_zero;
                    r_borrow <= 1'b0;
                end
            endcase
        end
    end

    assign count   = r_count;
    assign borrow  = r_borrow;
    assign running = (r_state == c_counting);
    assign expired = (r_state == c_expired);

endmodule
`default_nettype wire

// File: tb/tb_sync_down_counter_with_load.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_down_counter_with_load
// Purpose  : Directed self-checking bench. Each step drives inputs, pushes
//            the expected post-edge outputs to a scoreboard queue, then pops
//            and compares them one time unit after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_down_counter_with_load;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             brw;
        logic             run;
        logic             exp;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] count;
    logic             borrow;
    logic             running;
    logic             expired;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    sync_down_counter_with_load #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count       (count),
        .borrow      (borrow),
        .running     (running),
        .expired     (expired)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        total++;
        assert (count === e.cnt) else begin
            bad++;
            $error("FAIL %s.count observed=%0d expected=%0d", tag, count, e.cnt);
        end
        total++;
        assert (borrow === e.brw) else begin
            bad++;
            $error("FAIL %s.borrow observed=%0b expected=%0b", tag, borrow, e.brw);
        end
        total++;
        assert (running === e.run) else begin
            bad++;
            $error("FAIL %s.running observed=%0b expected=%0b", tag, running, e.run);
        end
        total++;
        assert (expired === e.exp) else begin
            bad++;
            $error("FAIL %s.expired observed=%0b expected=%0b", tag, expired, e.exp);
        end
    endtask

    // Drive one cycle of stimulus and the outputs expected after its edge.
    task automatic step(input string tag, input logic rst_n, input logic ld,
                        input logic en, input logic ar,
                        input logic [WIDTH-1:0] lv,
                        input logic [WIDTH-1:0] ec, input logic eb,
                        input logic er, input logic ee);
        exp_t e;
        reset       = rst_n;
        load        = ld;
        enable      = en;
        auto_reload = ar;
        load_value  = lv;
        e.cnt = ec;
        e.brw = eb;
        e.run = er;
        e.exp = ee;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check(tag);
    endtask

    initial begin
        #2;
        // Reset held for two edges.
        step("rst0", 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        step("rst1", 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0);
        // IDLE ignores enable.
        step("idle", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0);

        // Load 5, count to zero, borrow once, then EXPIRED.
        step("ld5", 1, 1, 1, 0, 4'd5, 4'd5, 0, 1, 0);
        for (int k = 4; k >= 0; k--)
            step("dn5", 1, 0, 1, 0, 4'd0, WIDTH'(k), 0, 1, 0);
        step("term5", 1, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);
        step("exp5", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);
        step("exp5b", 1, 0, 1, 1, 4'd0, 4'd0, 0, 0, 1);

        // Auto-reload with 3: period of four enabled cycles.
        step("ld3", 1, 1, 1, 1, 4'd3, 4'd3, 0, 1, 0);
        for (int p = 0; p < 3; p++) begin
            step("ar2", 1, 0, 1, 1, 4'd0, 4'd2, 0, 1, 0);
            step("ar1", 1, 0, 1, 1, 4'd0, 4'd1, 0, 1, 0);
            step("ar0", 1, 0, 1, 1, 4'd0, 4'd0, 0, 1, 0);
            step("ar3", 1, 0, 1, 1, 4'd0, 4'd3, 1, 1, 0);
        end

        // Enable gating after loading 9.
        step("ld9", 1, 1, 1, 0, 4'd9, 4'd9, 0, 1, 0);
        step("g1", 1, 0, 1, 0, 4'd0, 4'd8, 0, 1, 0);
        step("g2", 1, 0, 1, 0, 4'd0, 4'd7, 0, 1, 0);
        step("g3", 1, 0, 0, 0, 4'd0, 4'd7, 0, 1, 0);
        step("g4", 1, 0, 0, 0, 4'd0, 4'd7, 0, 1, 0);
        step("g5", 1, 0, 1, 0, 4'd0, 4'd6, 0, 1, 0);

        // Run down to zero, then load on the terminal-count edge.
        for (int k = 5; k >= 0; k--)
            step("dn6", 1, 0, 1, 0, 4'd0, WIDTH'(k), 0, 1, 0);
        // Pause at zero: no borrow while enable is low.
        step("pz", 1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0);
        step("ldterm", 1, 1, 1, 0, 4'hF, 4'd15, 0, 1, 0);

        // Mid-operation reset overriding a simultaneous load.
        for (int k = 14; k >= 6; k--)
            step("dn15", 1, 0, 1, 0, 4'd0, WIDTH'(k), 0, 1, 0);
        step("rstld", 0, 1, 1, 0, 4'hA, 4'd0, 0, 0, 0);
        for (int c = 0; c < 5; c++)
            step("idle5", 1, 0, 1, 0, 4'hA, 4'd0, 0, 0, 0);

        // Load zero without reload: borrow on first enabled edge.
        step("ld0", 1, 1, 1, 0, 4'd0, 4'd0, 0, 1, 0);
        step("term0", 1, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);
        step("exp0", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);

        // Load 15 from EXPIRED: sixteen enabled cycles to terminal, no wrap.
        step("ldF", 1, 1, 1, 0, 4'hF, 4'd15, 0, 1, 0);
        for (int k = 14; k >= 0; k--)
            step("dnF", 1, 0, 1, 0, 4'd0, WIDTH'(k), 0, 1, 0);
        step("termF", 1, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);
        step("expF", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_down_counter_with_load.md
# sync_down_counter_with_load

Synchronous, loadable down-counter/timer with terminal-count borrow pulse and optional auto-reload. Companion to the lab's up-counter set: counts in the opposite direction, from a software-loaded value down to zero. Serves as a programmable delay/period generator; `borrow` is the event output consumed by downstream lab blocks. Fully synchronous, single clock domain.

## Interface
- `WIDTH`, default 4, counter and load-value width in bits.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `enable`  in  1  count enable; when low, all state holds.
- `load`  in  1  parallel-load strobe; priority over `enable`.
- `load_value`  in  WIDTH  value captured on `load`.
- `auto_reload`  in  1  1: reload on terminal count; 0: stop at zero.
- `count`  out  WIDTH  current count, registered.
- `borrow`  out  1  one-cycle registered pulse on terminal count.
- `running`  out  1  high while in COUNTING.
- `expired`  out  1  high while in EXPIRED.

## Operation
- Internal reload register `reload_reg[WIDTH-1:0]` holds the last `load_value`.
- FSM states are IDLE, COUNTING and EXPIRED.
- `running` = (state == COUNTING) and `expired` = (state == EXPIRED). Both decode registered state; no combinational path from inputs.
- Priority per edge: `reset` low, then `load`, then `enable`, then hold.
- Reset (`reset`=0 at edge):
  - state = IDLE; `count` = 0; `reload_reg` = 0; `borrow` = 0.
  - Resulting outputs: `running` = 0, `expired` = 0.
  - Applies mid-count and overrides a simultaneous `load`.
- `load`=1, in any state: `count` ← `load_value`, `reload_reg` ← `load_value`, state ← COUNTING, `borrow` ← 0.
  - A load during the terminal-count cycle suppresses that borrow.
- IDLE: `enable` ignored; `count` holds; `borrow` = 0.
- COUNTING with `enable`=1:
  - `count` ≠ 0: `count` ← `count` − 1; `borrow` ← 0.
  - `count` = 0 (terminal): `borrow` ← 1.
    - If `auto_reload`=1: `count` ← `reload_reg`; stay in COUNTING.
    - If `auto_reload`=0: `count` stays 0; state ← EXPIRED.
- COUNTING with `enable`=0: all state holds; `borrow` ← 0. A pause never produces or stretches a borrow.
- EXPIRED: `count` holds 0; `borrow` = 0; `enable` ignored; only `load` or `reset` leaves.
- Arithmetic is modulo 2^WIDTH. There is no underflow past 0: the terminal branch replaces the decrement.
- `load_value` = 0 with `auto_reload`=1 gives a `borrow` on every enabled cycle.
- `auto_reload` is sampled only at the terminal-count edge.

## Timing
- Load latency: `count` = `load_value` immediately after the load edge.
- With `load_value` = V loaded at edge N and `enable` held high:
  - `count` = V−k after edge N+k, for k ≤ V.
  - `borrow` is high after edge N+V+1, for exactly one cycle.
- Auto-reload period: V+1 enabled cycles between successive borrow pulses.
- Each low-`enable` cycle delays all later events by one cycle.
- All outputs are registered or decoded from registered state only.

## Test plan
- Reset/load: hold `reset`=0 for 2 edges, then `reset`=1 and `load_value`=4'd5 with `load`=1 for 1 cycle, `enable`=1.
  - After reset: `count`=0, `borrow`=0, `running`=0, `expired`=0.
  - Count sequence: 5,4,3,2,1,0.
  - `borrow` high for exactly the one cycle after `count`=0 is consumed; then `expired`=1, `count`=0.
- Auto-reload: `load_value`=4'd3, `auto_reload`=1, `enable`=1, run 12 cycles.
  - `count` = 3,2,1,0,3,2,1,0,…
  - `borrow` pulses every 4 cycles, coincident with `count` returning to 3.
- Enable gating: `load_value`=4'd9, then `enable` pattern 1,1,0,0,1.
  - `count` = 8,7,7,7,6; `borrow` stays 0.
- Load vs. terminal: at `count`=0 in COUNTING, assert `load`=1 with `load_value`=4'hF.
  - Result: `count`=15, `borrow`=0, `running`=1.
- Mid-operation reset: at `count`=4'd6, drive `reset`=0 and `load`=1 on the same edge.
  - Result: `count`=0, state IDLE; with `enable`=1 and no load, `count` stays 0 for 5 cycles.
- Edge values: `load_value`=0 with `auto_reload`=0.
  - Result: `borrow` on the first enabled edge, then EXPIRED.
  - With `load_value`=4'hF and `enable`=1: 16 enabled cycles to terminal count, no wrap to 15 without reload.
